// File: rtl/multi_timer.sv
// multi_timer: N-channel down-counting timer with a shared prescaler on the simple system bus.
// Optional build macro MULTI_TIMER_CHAIN_EN: channel n>0 may step on channel n-1's expiry.
module multi_timer #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned CounterWidth   = 32,
  parameter int unsigned PrescalerWidth = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [DataWidth/8-1:0]    be_i,
  input  logic [AddressWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]      wdata_i,
  output logic                      rvalid_o,
  output logic [DataWidth-1:0]      rdata_o,
  output logic                      err_o,
  output logic                      irq_o
);

  localparam int unsigned BeW = DataWidth / 8;

  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [DataWidth-1:0]      rdata_q, rdata_d;
  logic [PrescalerWidth-1:0] presc_q, presc_d;
  logic [PrescalerWidth-1:0] pcnt_q, pcnt_d;
  logic [NumChannels-1:0]    en_q, en_d, per_q, per_d, ien_q, ien_d, pend_q, pend_d;
  logic [CounterWidth-1:0]   count_q [NumChannels];
  logic [CounterWidth-1:0]   count_d [NumChannels];
  logic [CounterWidth-1:0]   load_q  [NumChannels];
  logic [CounterWidth-1:0]   load_d  [NumChannels];
`ifdef MULTI_TIMER_CHAIN_EN
  logic [NumChannels-1:0]    chain_q, chain_d, expire_q, expire_d;
  logic [NumChannels-1:0]    prev_exp;
`endif

  logic [9:0]           a;
  logic [3:0]           ch_idx;
  logic [1:0]           reg_sel;
  logic                 chan_ok, is_presc, is_irqst, acc_err, wr_en, tick;
  logic [DataWidth-1:0] wmask;
  logic [AddressWidth-11:0] unused_addr;

  assign a           = addr_i[9:0];
  assign unused_addr = addr_i[AddressWidth-1:10];
  assign ch_idx      = a[7:4];
  assign reg_sel     = a[3:2];
  assign chan_ok     = (a[9:8] == 2'b00) && (32'(ch_idx) < NumChannels);
  assign is_presc    = (a == 10'h100);
  assign is_irqst    = (a == 10'h104);
  assign acc_err     = (a[1:0] != 2'b00) || !(chan_ok || is_presc || is_irqst);
  assign wr_en       = req_i && we_i && !acc_err;
  assign tick        = (pcnt_q == presc_q);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(BeW); b++) wmask[b*8 +: 8] = {8{be_i[b]}};
  end

  function automatic logic [DataWidth-1:0] merge_be(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [DataWidth-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = tick ? '0 : pcnt_q + PrescalerWidth'(1);
    if (wr_en && is_presc) begin
      presc_d = PrescalerWidth'(merge_be(DataWidth'(presc_q), wdata_i, wmask));
      pcnt_d  = '0;
    end
  end

`ifdef MULTI_TIMER_CHAIN_EN
  assign prev_exp = expire_q << 1;
`endif

  // A COUNT write in the same cycle as a step wins and suppresses that cycle's expiry.
  always_comb begin
    logic sel, step, count_wr, expire;
    en_d  = en_q;
    per_d = per_q;
    ien_d = ien_q;
    pend_d = pend_q;
`ifdef MULTI_TIMER_CHAIN_EN
    chain_d  = chain_q;
    expire_d = '0;
`endif
    for (int i = 0; i < int'(NumChannels); i++) begin
      count_d[i] = count_q[i];
      load_d[i]  = load_q[i];
      sel        = wr_en && chan_ok && (ch_idx == 4'(i));
      count_wr   = sel && (reg_sel == 2'd2) && (|be_i);
      step       = tick;
      expire     = 1'b0;
`ifdef MULTI_TIMER_CHAIN_EN
      if (chain_q[i]) step = prev_exp[i];
`endif
      if (en_q[i] && step && !count_wr) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - CounterWidth'(1);
        end else begin
          expire = 1'b1;
          if (per_q[i]) count_d[i] = load_q[i];
          else          en_d[i]    = 1'b0;
        end
      end
`ifdef MULTI_TIMER_CHAIN_EN
      expire_d[i] = expire;
`endif
      if (sel && reg_sel == 2'd0 && be_i[0]) begin
        en_d[i]  = wdata_i[0];
        per_d[i] = wdata_i[1];
        ien_d[i] = wdata_i[2];
`ifdef MULTI_TIMER_CHAIN_EN
        chain_d[i] = (i > 0) ? wdata_i[3] : 1'b0;
`endif
      end
      if (sel && reg_sel == 2'd1)
        load_d[i] = CounterWidth'(merge_be(DataWidth'(load_q[i]), wdata_i, wmask));
      if (count_wr)
        count_d[i] = CounterWidth'(merge_be(DataWidth'(count_q[i]), wdata_i, wmask));
      if (sel && reg_sel == 2'd3 && be_i[0] && wdata_i[0]) pend_d[i] = 1'b0;
      if (expire) pend_d[i] = 1'b1;
    end
  end

  always_comb begin
    rvalid_d = req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (req_i) begin
      if (acc_err) begin
        err_d = 1'b1;
      end else if (!we_i) begin
        if (is_presc) begin
          rdata_d = DataWidth'(presc_q);
        end else if (is_irqst) begin
          rdata_d = DataWidth'(pend_q);
        end else begin
          for (int i = 0; i < int'(NumChannels); i++) begin
            if (ch_idx == 4'(i)) begin
              case (reg_sel)
`ifdef MULTI_TIMER_CHAIN_EN
                2'd0:    rdata_d = DataWidth'({chain_q[i], ien_q[i], per_q[i], en_q[i]});
`else
                2'd0:    rdata_d = DataWidth'({1'b0, ien_q[i], per_q[i], en_q[i]});
`endif
                2'd1:    rdata_d = DataWidth'(load_q[i]);
                2'd2:    rdata_d = DataWidth'(count_q[i]);
                default: rdata_d = DataWidth'(pend_q[i]);
              endcase
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      en_q     <= '0;
      per_q    <= '0;
      ien_q    <= '0;
      pend_q   <= '0;
      count_q  <= '{default: '0};
      load_q   <= '{default: '0};
`ifdef MULTI_TIMER_CHAIN_EN
      chain_q  <= '0;
      expire_q <= '0;
`endif
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      en_q     <= en_d;
      per_q    <= per_d;
      ien_q    <= ien_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
      load_q   <= load_d;
`ifdef MULTI_TIMER_CHAIN_EN
      chain_q  <= chain_d;
      expire_q <= expire_d;
`endif
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign irq_o    = |(pend_q & ien_q);

endmodule

// File: tb/tb_multi_timer.sv
// Directed testbench for multi_timer: bus access, prescaler, one-shot/periodic, errors, boundaries.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        rvalid_o, err_o, irq_o;
  logic [31:0] rdata_o;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  multi_timer dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the response sampled.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic err);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check("rvalid", {31'd0, rvalid_o}, 32'd1);
    rd  = rdata_o;
    err = err_o;
  endtask

  task automatic wr_be(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd;
    logic        err;
    bus(1'b1, addr, wd, be, rd, err);
    check("wr_err", {31'd0, err}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    wr_be(addr, wd, 4'hF);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    bus(1'b0, addr, 32'd0, 4'hF, rd, err);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check(tag, rd, exp);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [31:0] addr);
    logic [31:0] rd;
    logic        err;
    bus(we, addr, 32'h0000_00FF, 4'hF, rd, err);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_rdata"}, rd, 32'd0);
  endtask

  task automatic wait_irq(input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (irq_o !== lvl && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);

    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        rd_chk($sformatf("rst_reg_%0d_%0d", c, r), 32'(c * 16 + r * 4), 32'd0);
    rd_chk("rst_presc", 32'h100, 32'd0);
    rd_chk("rst_irqst", 32'h104, 32'd0);

    // periodic ch0, LOAD=COUNT=3, tick every cycle
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h7);
    wait_irq(1'b1, 20, n);
    check("per_first_expiry", 32'(n), 32'd4);
    rd_chk("per_reload", 32'h08, 32'd3);
    rd_chk("per_count2", 32'h08, 32'd2);
    wr(32'h0C, 32'd1);
    check("per_w1c_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    check("per_second_expiry", {31'd0, irq_o}, 32'd1);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'd1);
    check("per_stop_irq", {31'd0, irq_o}, 32'd0);

    // error responses, no side effects, byte enables
    err_chk("err_ch5_rd", 1'b0, 32'h50);
    err_chk("err_ch5_wr", 1'b1, 32'h58);
    err_chk("err_off200", 1'b1, 32'h200);
    err_chk("err_off108", 1'b0, 32'h108);
    err_chk("err_misalign", 1'b1, 32'h101);
    err_chk("err_misalign_rd", 1'b0, 32'h102);
    rd_chk("presc_untouched", 32'h100, 32'd0);
    wr(32'h104, 32'hFF);
    rd_chk("irqst_ro", 32'h104, 32'd0);
    wr_be(32'h04, 32'hAABB_CCDD, 4'h1);
    rd_chk("load_be1", 32'h04, 32'h0000_00DD);
    wr_be(32'h04, 32'h1122_3344, 4'h6);
    rd_chk("load_be6", 32'h04, 32'h0022_33DD);

    // one-shot ch1 with PRESCALE=4: ticks land 4,9,14 cycles after EN is set
    wr(32'h18, 32'd2);
    wr(32'h100, 32'd4);
    wr(32'h10, 32'h5);
    wait_irq(1'b1, 30, n);
    check("oneshot_expiry", 32'(n), 32'd14);
    rd_chk("oneshot_ctrl", 32'h10, 32'h4);
    rd_chk("oneshot_count", 32'h18, 32'd0);
    rd_chk("oneshot_irqst", 32'h104, 32'h2);
    wr(32'h1C, 32'd1);
    check("oneshot_w1c_irq", {31'd0, irq_o}, 32'd0);
    wr(32'h100, 32'd0);

    // COUNT write in the expiry cycle wins; then freeze and resume
    wr(32'h28, 32'd1);
    wr(32'h20, 32'h5);
    @(negedge clk);
    wr(32'h28, 32'd9);
    rd_chk("cntwr_count", 32'h28, 32'd9);
    rd_chk("cntwr_nopend", 32'h2C, 32'd0);
    wr(32'h20, 32'h0);
    rd_chk("freeze_count", 32'h28, 32'd6);
    rd_chk("freeze_hold", 32'h28, 32'd6);
    wr(32'h20, 32'h1);
    rd_chk("resume_count0", 32'h28, 32'd6);
    rd_chk("resume_count1", 32'h28, 32'd5);
    wr(32'h20, 32'h0);

    // W1C in the expiry cycle keeps PENDING
    wr(32'h38, 32'd1);
    wr(32'h30, 32'h1);
    @(negedge clk);
    wr(32'h3C, 32'd1);
    rd_chk("w1c_race_pend", 32'h3C, 32'd1);
    rd_chk("w1c_race_en", 32'h30, 32'd0);
    wr(32'h3C, 32'd1);
    rd_chk("w1c_clear", 32'h3C, 32'd0);

    // CHAIN on ch0 never reads back
    wr(32'h00, 32'h8);
    rd_chk("chain_ch0", 32'h00, 32'h0);
`ifdef MULTI_TIMER_CHAIN_EN
    wr(32'h18, 32'd2);
    wr(32'h10, 32'hD);
    wr(32'h04, 32'd1);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h3);
    wait_irq(1'b1, 30, n);
    check("chain_expiry", 32'(n), 32'd7);
    rd_chk("chain_ctrl1", 32'h10, 32'hC);
    wr(32'h00, 32'h0);
    wr(32'h1C, 32'd1);
`else
    wr(32'h10, 32'h8);
    rd_chk("chain_ch1_off", 32'h10, 32'h0);
`endif

    // reset mid-count, with a request in the reset cycle
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h7);
    @(negedge clk);
    check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h08;
    @(negedge clk);
    rst_i = 1'b0; req_i = 1'b0;
    check("rst_drop_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_mid_irq", {31'd0, irq_o}, 32'd0);
    rd_chk("rst_mid_ctrl", 32'h00, 32'd0);
    rd_chk("rst_mid_count", 32'h08, 32'd0);
    rd_chk("rst_mid_load", 32'h04, 32'd0);
    rd_chk("rst_mid_presc", 32'h100, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
